// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int TO_W_DEFAULT = 8;

endpackage

// File: rtl/wb_arb_2m1s_if.sv
// rtl/wb_arb_2m1s_if.sv - one Wishbone classic port (request plus response)
interface wb_arb_2m1s_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW >> 3;

  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic          we;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  modport master (
    output adr, sel, we, dat_w, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, sel, we, dat_w, cyc, stb,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stall counter that flags a slave that never answers a strobe
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TO_W = TO_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gnt,
  input  logic       stb,
  input  logic       ack,
  input  logic       err,
  output logic       to_err
);

  logic [TO_W-1:0] cnt;
  logic [1:0]      gnt_q;
  logic            gnt_chg;

  assign gnt_chg = (gnt != gnt_q);
  assign to_err  = stb && (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      gnt_q <= 2'b00;
    end else begin
      gnt_q <= gnt;
      if (to_err || ack || err) begin
        cnt <= '0;
      end else if (gnt_chg) begin
        // the first strobe cycle of a new tenure already counts as waiting
        cnt <= TO_W'(stb);
      end else if (stb) begin
        cnt <= cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_arb_2m1s.sv
// rtl/wb_arb_2m1s.sv - cyc-locked round-robin arbiter, two Wishbone masters onto one slave
// Define WB_ARB_TIMEOUT_EN to terminate stalled slave cycles with err.
module wb_arb_2m1s
  import wb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef WB_ARB_TIMEOUT_EN
  , parameter int TO_W = TO_W_DEFAULT
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arb_2m1s_if.slave  m0,
  wb_arb_2m1s_if.slave  m1,
  wb_arb_2m1s_if.master s,
  output logic [1:0]    gnt
);

  localparam int SW = DW >> 3;

  arb_state_t state;
  logic       last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= M1;
      gnt   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last == M1)) begin
            state <= GNT0;
            last  <= M0;
            gnt   <= 2'b01;
          end else if (m1.cyc) begin
            state <= GNT1;
            last  <= M1;
            gnt   <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0.cyc) begin
            if (m1.cyc) begin
              state <= GNT1;
              last  <= M1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!m1.cyc) begin
            if (m0.cyc) begin
              state <= GNT0;
              last  <= M0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  logic [AW-1:0] adr_mux;
  logic [SW-1:0] sel_mux;
  logic          we_mux;
  logic [DW-1:0] dat_mux;
  logic          cyc_mux;
  logic          stb_mux;

  // Non-cycle fields default to master 0 so an idle bus stays quiet and predictable.
  always_comb begin
    adr_mux = m0.adr;
    sel_mux = m0.sel;
    we_mux  = m0.we;
    dat_mux = m0.dat_w;
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    if (gnt[1]) begin
      adr_mux = m1.adr;
      sel_mux = m1.sel;
      we_mux  = m1.we;
      dat_mux = m1.dat_w;
      cyc_mux = m1.cyc;
      stb_mux = m1.stb;
    end else if (gnt[0]) begin
      cyc_mux = m0.cyc;
      stb_mux = m0.stb;
    end
  end

  assign s.adr   = adr_mux;
  assign s.sel   = sel_mux;
  assign s.we    = we_mux;
  assign s.dat_w = dat_mux;
  assign s.cyc   = cyc_mux;
  assign s.stb   = stb_mux;

  logic          to_err;
  logic [DW-1:0] rdata;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .gnt    (gnt),
    .stb    (stb_mux),
    .ack    (s.ack),
    .err    (s.err),
    .to_err (to_err)
  );
`else
  assign to_err = 1'b0;
`endif

  // Responses follow the registered grant, so an ack landing as cyc drops still reaches its owner.
  assign rdata    = s.dat_r;
  assign m0.dat_r = rdata;
  assign m1.dat_r = rdata;
  assign m0.ack   = s.ack & gnt[0];
  assign m1.ack   = s.ack & gnt[1];
  assign m0.err   = (s.err | to_err) & gnt[0];
  assign m1.err   = (s.err | to_err) & gnt[1];

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: tb/tb_wb_arb_2m1s.sv
// tb/tb_wb_arb_2m1s.sv - directed vectors for wb_arb_2m1s with a small GPIO slave model
module tb_wb_arb_2m1s;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_arb_2m1s_if m0_bus ();
  wb_arb_2m1s_if m1_bus ();
  wb_arb_2m1s_if s_bus ();
  logic [1:0] gnt;

  wb_arb_2m1s dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt   (gnt)
  );

  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];

  assign m0_bus.cyc = m_cyc[0];  assign m1_bus.cyc = m_cyc[1];
  assign m0_bus.stb = m_stb[0];  assign m1_bus.stb = m_stb[1];
  assign m0_bus.we  = m_we[0];   assign m1_bus.we  = m_we[1];
  assign m0_bus.adr = m_adr[0];  assign m1_bus.adr = m_adr[1];
  assign m0_bus.dat_w = m_dat[0]; assign m1_bus.dat_w = m_dat[1];
  assign m0_bus.sel = m_sel[0];  assign m1_bus.sel = m_sel[1];

  // GPIO slave: registered single-cycle ack, read data valid only alongside ack
  logic [1:0]  gpio_o, gpio_i;
  logic        stall;
  logic        s_ack;
  logic [31:0] s_rdat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack  <= 1'b0;
      s_rdat <= '0;
      gpio_o <= 2'b00;
    end else begin
      s_ack  <= s_bus.cyc && s_bus.stb && !s_ack && !stall;
      s_rdat <= '0;
      if (s_bus.cyc && s_bus.stb && !s_ack && !stall) begin
        if (s_bus.we && s_bus.sel[0]) gpio_o <= s_bus.dat_w[1:0];
        if (!s_bus.we) s_rdat <= {30'b0, gpio_i};
      end
    end
  end
  assign s_bus.ack   = s_ack;
  assign s_bus.dat_r = s_rdat;
  assign s_bus.err   = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int bad_ack = 0;
  int err_seen [2] = '{0, 0};
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_bus.ack && !gnt[0]) bad_ack++;
      if (m1_bus.ack && !gnt[1]) bad_ack++;
      if (m0_bus.err) err_seen[0]++;
      if (m1_bus.err) err_seen[1]++;
    end
  end

  task automatic master_run(input int m, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input int beats, input int limit,
                            output int nack, output int nerr, output int t_end,
                            output logic [31:0] rdata);
    int t = 0;
    nack = 0; nerr = 0; t_end = 0; rdata = '0;
    @(posedge clk); #1;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat[m] = dat;  m_sel[m] = 4'hf;
    forever begin
      @(negedge clk);
      if ((m == 0) ? m0_bus.ack : m1_bus.ack) begin
        nack++;
        rdata = (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
      end
      if ((m == 0) ? m0_bus.err : m1_bus.err) nerr++;
      t_end = t;
      if (nack >= beats || nerr != 0 || t >= limit) break;
      t++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  logic [1:0] gnt_log [$];
  logic [1:0] exp_hand  [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
  logic [1:0] exp_block [9] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int na0, ne0, te0, na1, ne1, te1, acc0, acc1, idle_mid, cyc_cnt, e0;
    logic [31:0] rd0, rd1;
    logic [1:0]  prev;
    logic        done;

    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_adr[i] = '0;   m_dat[i] = '0;   m_sel[i] = '0;
    end
    gpio_i = 2'b00;
    stall  = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_gnt",    32'(gnt), 0);
    check_val("rst_s_cyc",  32'(s_bus.cyc), 0);
    check_val("rst_s_stb",  32'(s_bus.stb), 0);
    check_val("rst_s_adr",  s_bus.adr, 0);
    check_val("rst_m0_ack", 32'(m0_bus.ack), 0);
    check_val("rst_m1_ack", 32'(m1_bus.ack), 0);
    check_val("rst_m0_err", 32'(m0_bus.err), 0);
    check_val("rst_m1_err", 32'(m1_bus.err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // m0 alone writes 0x3 to GPIO
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[0] = 32'h10; m_dat[0] = 32'h3; m_sel[0] = 4'hf;
    @(negedge clk);
    check_val("t1_gnt_c0",  32'(gnt), 0);
    check_val("t1_scyc_c0", 32'(s_bus.cyc), 0);
    @(negedge clk);
    check_val("t1_gnt_c1",   32'(gnt), 1);
    check_val("t1_scyc_c1",  32'(s_bus.cyc), 1);
    check_val("t1_sstb_c1",  32'(s_bus.stb), 1);
    check_val("t1_swe_c1",   32'(s_bus.we), 1);
    check_val("t1_sadr_c1",  s_bus.adr, 32'h10);
    check_val("t1_sdat_c1",  s_bus.dat_w, 32'h3);
    check_val("t1_m0ack_c1", 32'(m0_bus.ack), 0);
    @(negedge clk);
    check_val("t1_m0ack_c2", 32'(m0_bus.ack), 1);
    check_val("t1_m1ack_c2", 32'(m1_bus.ack), 0);
    check_val("t1_gpio",     32'(gpio_o), 3);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    repeat (2) @(posedge clk);

    // reset while an ack is on the bus
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_dat[0] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("mrst_pre_ack", 32'(m0_bus.ack), 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("mrst_gnt",   32'(gnt), 0);
    check_val("mrst_m0ack", 32'(m0_bus.ack), 0);
    check_val("mrst_scyc",  32'(s_bus.cyc), 0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // simultaneous request after reset, then handoff without idle
    gnt_log.delete();
    fork
      master_run(0, 1'b1, 32'h0, 32'h1, 1, 50, na0, ne0, te0, rd0);
      master_run(1, 1'b1, 32'h0, 32'h2, 1, 50, na1, ne1, te1, rd1);
      begin
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          gnt_log.push_back(gnt);
        end
      end
    join
    for (int i = 0; i < 8; i++)
      check_val($sformatf("hand_gnt_c%0d", i), 32'(gnt_log[i]), 32'(exp_hand[i]));
    check_val("hand_m0_acks", na0, 1);
    check_val("hand_m1_acks", na1, 1);
    check_val("hand_gpio",    32'(gpio_o), 2);
    repeat (2) @(posedge clk);

    // continuous contention: four single-beat cycles each
    gnt_log.delete();
    acc0 = 0; acc1 = 0; idle_mid = 0; cyc_cnt = 0; prev = 2'b00; done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 4; i++) begin
            master_run(0, 1'b1, 32'h0, 32'h1, 1, 50, na0, ne0, te0, rd0);
            acc0 += na0;
          end
          for (int i = 0; i < 4; i++) begin
            master_run(1, 1'b1, 32'h0, 32'h2, 1, 50, na1, ne1, te1, rd1);
            acc1 += na1;
          end
        join
        done = 1'b1;
      end
      while (!done && cyc_cnt < 400) begin
        @(negedge clk);
        if (gnt != prev && gnt != 2'b00) gnt_log.push_back(gnt);
        if (gnt == 2'b00 && gnt_log.size() > 0 && gnt_log.size() < 8) idle_mid++;
        prev = gnt;
        cyc_cnt++;
      end
    join
    check_val("rr_grants", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      check_val($sformatf("rr_gnt_%0d", i), 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    check_val("rr_idle_gaps", idle_mid, 0);
    check_val("rr_m0_acks", acc0, 4);
    check_val("rr_m1_acks", acc1, 4);
    repeat (2) @(posedge clk);

    // m1 holds a 3-beat block while m0 waits
    gnt_log.delete();
    fork
      master_run(1, 1'b1, 32'h4, 32'h1, 3, 50, na1, ne1, te1, rd1);
      begin
        @(posedge clk);
        master_run(0, 1'b1, 32'h0, 32'h3, 1, 50, na0, ne0, te0, rd0);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          gnt_log.push_back(gnt);
        end
      end
    join
    for (int i = 0; i < 9; i++)
      check_val($sformatf("blk_gnt_c%0d", i), 32'(gnt_log[i]), 32'(exp_block[i]));
    check_val("blk_m1_acks", na1, 3);
    check_val("blk_m0_acks", na0, 1);
    repeat (2) @(posedge clk);

    // m1 reads GPIO input
    gpio_i = 2'b10;
    master_run(1, 1'b0, 32'h8, 32'h0, 1, 50, na1, ne1, te1, rd1);
    check_val("rd_m1_acks", na1, 1);
    check_val("rd_m1_dat",  rd1, 32'h2);
    check_val("rd_latency", te1, 2);
    repeat (2) @(posedge clk);

    // stalled slave
    stall = 1'b1;
    e0 = err_seen[0];
    master_run(0, 1'b1, 32'h0, 32'h0, 1, 300, na0, ne0, te0, rd0);
    repeat (4) @(posedge clk);
`ifdef WB_ARB_TIMEOUT_EN
    check_val("wd_err",       ne0, 1);
    check_val("wd_err_cycle", te0, 256);
    check_val("wd_err_width", err_seen[0] - e0, 1);
`else
    check_val("nowd_err",     ne0, 0);
    check_val("nowd_hang",    te0, 300);
    check_val("nowd_err_cnt", err_seen[0] - e0, 0);
`endif
    check_val("stall_acks", na0, 0);
    stall = 1'b0;
    repeat (3) @(posedge clk);

`ifndef WB_ARB_TIMEOUT_EN
    check_val("m0_err_total", err_seen[0], 0);
`endif
    check_val("m1_err_total", err_seen[1], 0);
    check_val("stray_acks",   bad_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
